// File: rtl/pt2272_pkg.sv
// Shared types and frame constants for the PT2272 decoder.
// Symbol encoding reuses the addr_i code (00=0, 11=1, 01=F, 10=reserved).
package pt2272_pkg;

  typedef enum logic [1:0] {
    SYM_0   = 2'b00,
    SYM_F   = 2'b01,
    SYM_BAD = 2'b10,
    SYM_1   = 2'b11
  } sym_t;

  typedef enum logic {
    SHORT = 1'b0,
    LONG  = 1'b1
  } pulse_t;

  typedef enum logic [2:0] {
    HUNT,
    READY,
    HIGH,
    LOW,
    CHECK
  } state_t;

  localparam int N_ADDR   = 8;
  localparam int N_DATA   = 4;
  localparam int N_SYM    = N_ADDR + N_DATA;
  localparam int N_PULSES = 25;

  // {first, second} maps straight onto the symbol code: SS=0, LL=1, SL=F, LS=bad.
  function automatic sym_t pair_to_sym(input pulse_t first, input pulse_t second);
    return sym_t'({first, second});
  endfunction

  // The reserved address code 10 never matches any received symbol.
  function automatic logic sym_matches(input sym_t s, input logic [1:0] a);
    return (a != 2'b10) && (s == sym_t'(a));
  endfunction

endpackage

// File: rtl/medidor_pulso.sv
// Input synchronizer, edge strobes and saturating high/low width counters
// for the PT2272 decoder; classifies each high pulse and flags sync gaps.
module medidor_pulso
  import pt2272_pkg::*;
#(
  parameter int CLK_DIV      = 250,
  parameter int LONG_MIN     = 8,
  parameter int PULSE_MAX    = 20,
  parameter int SYNC_GAP_MIN = 40
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cod_i,
  output logic   rise_o,
  output logic   fall_o,
  output pulse_t class_o,
  output logic   too_long_o,
  output logic   gap_o
);

  localparam int CNT_W = $clog2(SYNC_GAP_MIN * CLK_DIV + PULSE_MAX * CLK_DIV + 2);
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_MIN * CLK_DIV);
  localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(PULSE_MAX * CLK_DIV);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(SYNC_GAP_MIN * CLK_DIV);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic             cod_p0, cod_p1, cod_p2;
  logic [CNT_W-1:0] high_cnt, low_cnt;

  // p0/p1: metastability filter; p2: previous level for edge detection
  always_ff @(posedge clk) begin
    cod_p0 <= cod_i;
    cod_p1 <= cod_p0;
    cod_p2 <= cod_p1;
  end

  assign rise_o = cod_p1 & ~cod_p2;
  assign fall_o = ~cod_p1 & cod_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      if (rise_o)      high_cnt <= CNT_W'(1);
      else if (cod_p1) high_cnt <= sat_inc(high_cnt);
      if (fall_o)      low_cnt  <= CNT_W'(1);
      else if (!cod_p1) low_cnt <= sat_inc(low_cnt);
    end
  end

  assign class_o    = (high_cnt >= LONG_LIM) ? LONG : SHORT;
  assign too_long_o = (high_cnt > MAX_LIM);
  // Equality gives a single strobe per gap because the counter saturates past it.
  assign gap_o      = ~cod_p1 && (low_cnt == GAP_LIM);

endmodule

// File: rtl/decodificador_pt2272.sv
// PT2272 receiver: frames PT2262 pulses into 12 trinary symbols, checks the address
// and latches data with a valid-transmission hold. Option: DOUBLE_FRAME_CHECK_EN.
module decodificador_pt2272
  import pt2272_pkg::*;
#(
  parameter int CLK_DIV      = 250,
  parameter int LONG_MIN     = 8,
  parameter int PULSE_MAX    = 20,
  parameter int SYNC_GAP_MIN = 40,
  parameter int VT_HOLD_OSC  = 1100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cod_i,
  input  logic [15:0] addr_i,
  output logic [3:0]  data_o,
  output logic        vt_o,
  output logic        err_o
);

  localparam int HOLD_CLK = VT_HOLD_OSC * CLK_DIV;
  localparam int HOLD_W   = $clog2(HOLD_CLK);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CLK - 1);
  localparam logic [4:0] LAST_IDX = 5'(N_PULSES - 1);
  localparam logic [4:0] FULL_IDX = 5'(N_PULSES);

  logic   rise, fall, too_long, gap;
  pulse_t pclass;

  medidor_pulso #(
    .CLK_DIV     (CLK_DIV),
    .LONG_MIN    (LONG_MIN),
    .PULSE_MAX   (PULSE_MAX),
    .SYNC_GAP_MIN(SYNC_GAP_MIN)
  ) u_medidor (
    .clk       (clk),
    .reset     (reset),
    .cod_i     (cod_i),
    .rise_o    (rise),
    .fall_o    (fall),
    .class_o   (pclass),
    .too_long_o(too_long),
    .gap_o     (gap)
  );

  state_t              state_q, state_d;
  logic [4:0]          idx_q, idx_d;
  logic                err_d, store_first, store_sym;
  pulse_t              first_q;
  sym_t                syms_q [N_SYM];
  sym_t                new_sym;
  logic                addr_ok, data_f, accept, update;
  logic [N_DATA-1:0]   data_bits;
  logic [HOLD_W-1:0]   hold_q;

  assign new_sym = pair_to_sym(first_q, pclass);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = 1'b0;
    store_first = 1'b0;
    store_sym   = 1'b0;
    unique case (state_q)
      HUNT:  if (gap) state_d = READY;
      READY: if (rise) begin
        state_d = HIGH;
        idx_d   = '0;
      end
      HIGH: begin
        if (too_long) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end else if (fall) begin
          // The 25th pulse is the sync pulse and must be SHORT.
          if (idx_q == LAST_IDX) begin
            if (pclass == LONG) begin
              err_d   = 1'b1;
              state_d = HUNT;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = LOW;
            end
          end else if (idx_q[0]) begin
            if (new_sym == SYM_BAD) begin
              err_d   = 1'b1;
              state_d = HUNT;
            end else begin
              store_sym = 1'b1;
              idx_d     = idx_q + 5'd1;
              state_d   = LOW;
            end
          end else begin
            store_first = 1'b1;
            idx_d       = idx_q + 5'd1;
            state_d     = LOW;
          end
        end
      end
      LOW: begin
        if (rise) begin
          if (idx_q == FULL_IDX) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            state_d = HIGH;
          end
        end else if (gap) begin
          // A premature gap still marks the start of the next frame.
          if (idx_q == FULL_IDX) begin
            state_d = CHECK;
          end else begin
            err_d   = 1'b1;
            state_d = READY;
          end
        end
      end
      CHECK: begin
        err_d   = data_f;
        state_d = READY;
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    addr_ok   = 1'b1;
    data_f    = 1'b0;
    data_bits = '0;
    for (int k = 0; k < N_ADDR; k++) begin
      if (!sym_matches(syms_q[k], addr_i[2*k +: 2])) addr_ok = 1'b0;
    end
    for (int k = 0; k < N_DATA; k++) begin
      if (syms_q[N_ADDR+k] == SYM_F) data_f = 1'b1;
      data_bits[N_DATA-1-k] = (syms_q[N_ADDR+k] == SYM_1);
    end
  end

  assign accept = (state_q == CHECK) && !data_f && addr_ok;

`ifdef DOUBLE_FRAME_CHECK_EN
  logic [2*N_SYM-1:0] frame_d, prev_q;
  logic               primed_q;

  always_comb begin
    frame_d = '0;
    for (int k = 0; k < N_SYM; k++) frame_d[2*k +: 2] = syms_q[k];
  end

  assign update = accept && primed_q && (frame_d == prev_q);

  always_ff @(posedge clk) begin
    if (reset)       primed_q <= 1'b0;
    else if (accept) primed_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) prev_q <= frame_d;
  end
`else
  assign update = accept;
`endif

  always_ff @(posedge clk) begin
    if (store_first) first_q <= pclass;
    if (store_sym)   syms_q[idx_q[4:1]] <= new_sym;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      idx_q   <= '0;
      err_o   <= 1'b0;
      vt_o    <= 1'b0;
      data_o  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_o   <= err_d;
      if (update) begin
        data_o <= data_bits;
        vt_o   <= 1'b1;
        hold_q <= HOLD_RELOAD;
      end else if (vt_o) begin
        if (hold_q == '0) vt_o   <= 1'b0;
        else              hold_q <= hold_q - HOLD_W'(1);
      end
    end
  end

endmodule
